// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared types and constants for the I2S transmit serializer.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Channel tag carried with each sample and reflected on lrclk.
  typedef enum logic {
    CHAN_L = 1'b0,
    CHAN_R = 1'b1
  } chan_t;

  // Width of one filtered audio sample (Q2.14).
  localparam int SAMPLE_W = 16;

  // Default BCLK periods per channel slot and system clocks per BCLK half.
  localparam int DEF_SLOT_BITS = 32;
  localparam int DEF_CLK_DIV   = 4;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer_if
// Brief    : Sample write port from the filter stage into the serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_tx_serializer_if;
  import i2s_pkg::*;

  logic signed [SAMPLE_W-1:0] in_sample;
  logic                       in_valid;
  chan_t                      in_chan;

  // Producer side (filter stage / testbench).
  modport master (
    output in_sample,
    output in_valid,
    output in_chan
  );

  // Consumer side (serializer).
  modport slave (
    input in_sample,
    input in_valid,
    input in_chan
  );

endinterface : i2s_tx_serializer_if
`default_nettype wire

// File: rtl/i2s_tx_serializer_bclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : bclk_gen
// Brief    : Divides the system clock down to BCLK and reports the clk cycle
//            on which BCLK rises or falls as single-cycle strobes.
// Revision : 1.0 - initial release
// ============================================================================
module bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  output logic      bclk,
  output logic      rise_evt,
  output logic      fall_evt
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_TERM = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             term;

  // Terminal count marks the clk edge on which bclk toggles.
  always_comb begin
    term     = (div_cnt == C_TERM);
    rise_evt = term & ~bclk;
    fall_evt = term &  bclk;
  end

  // Divider counter and bclk toggle flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (term) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule : bclk_gen
`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer
// Brief    : Holds one sample per channel and shifts them out to the DAC in
//            standard I2S framing (MSB one BCLK after the lrclk edge), while
//            generating bclk/lrclk from the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int SLOT_BITS = DEF_SLOT_BITS
) (
  input  wire logic            clk,
  input  wire logic            reset,
  i2s_tx_serializer_if.slave   in_bus,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 underrun,
  output logic                 overrun
);

  localparam int BIT_W = $clog2(SLOT_BITS);
  localparam logic [BIT_W-1:0] C_BIT_LAST = BIT_W'(SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] C_BIT_MSB  = BIT_W'(SAMPLE_W);

  // Divider strobes; the rise strobe is not needed by the transmit path.
  logic fall_evt;
  logic unused_rise_evt;

  // Channel storage.
  logic [SAMPLE_W-1:0] hold_l;
  logic [SAMPLE_W-1:0] hold_r;
  logic                fresh_l;
  logic                fresh_r;

  // Serializer state.
  logic [BIT_W-1:0]    bit_cnt;
  logic [SAMPLE_W-1:0] shift_reg;
  logic                first_slot;

  // Combinational decode.
  logic [BIT_W-1:0]    bit_nxt;
  logic                slot_load;
  logic                load_r;
  logic                wr_l;
  logic                wr_r;
  logic                load_l_evt;
  logic                load_r_evt;
  logic                bypass;
  logic                load_fresh;
  logic [SAMPLE_W-1:0] load_val;
  logic                stale;
  logic                clobber;

  bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .reset    (reset),
    .bclk     (bclk),
    .rise_evt (unused_rise_evt),
    .fall_evt (fall_evt)
  );

  // Slot boundary, channel select, write decode and flag conditions.
  always_comb begin
    bit_nxt    = (bit_cnt == C_BIT_LAST) ? '0 : bit_cnt + 1'b1;
    slot_load  = fall_evt && (bit_nxt == '0);
    // lrclk is about to toggle, so the new channel is right when lrclk is 0.
    load_r     = ~lrclk;
    wr_l       = in_bus.in_valid && (in_bus.in_chan == CHAN_L);
    wr_r       = in_bus.in_valid && (in_bus.in_chan == CHAN_R);
    load_l_evt = slot_load && !load_r;
    load_r_evt = slot_load &&  load_r;
    // A write landing on its own channel's load goes straight to the shifter.
    bypass     = load_r ? wr_r : wr_l;
    load_fresh = load_r ? fresh_r : fresh_l;
    if (bypass) begin
      load_val = in_bus.in_sample;
    end else begin
      load_val = load_r ? hold_r : hold_l;
    end
    stale      = slot_load && !bypass && !load_fresh && !first_slot;
    clobber    = (wr_l && fresh_l && !load_l_evt) ||
                 (wr_r && fresh_r && !load_r_evt);
  end

  // Holding registers, fresh flags and the overrun pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_l  <= '0;
      hold_r  <= '0;
      fresh_l <= 1'b0;
      fresh_r <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= clobber;
      if (wr_l) begin
        hold_l <= in_bus.in_sample;
      end
      if (wr_r) begin
        hold_r <= in_bus.in_sample;
      end
      if (load_l_evt) begin
        fresh_l <= 1'b0;
      end else if (wr_l) begin
        fresh_l <= 1'b1;
      end
      if (load_r_evt) begin
        fresh_r <= 1'b0;
      end else if (wr_r) begin
        fresh_r <= 1'b1;
      end
    end
  end

  // Bit counter, lrclk, shift register and sdata, all advanced on BCLK falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= C_BIT_LAST;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      shift_reg  <= '0;
      first_slot <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      underrun <= stale;
      if (fall_evt) begin
        bit_cnt <= bit_nxt;
        if (slot_load) begin
          // Bit 0 of every slot is the one-BCLK I2S padding bit.
          lrclk      <= ~lrclk;
          shift_reg  <= load_val;
          first_slot <= 1'b0;
          sdata      <= 1'b0;
        end else if (bit_nxt <= C_BIT_MSB) begin
          sdata     <= shift_reg[SAMPLE_W-1];
          shift_reg <= {shift_reg[SAMPLE_W-2:0], 1'b0};
        end else begin
          sdata <= 1'b0;
        end
      end
    end
  end

endmodule : i2s_tx_serializer
`default_nettype wire

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Transmit end of the audio sample path. Accepts 16-bit signed filtered samples tagged left/right from the biquad filter stage, holds one sample per channel, and serializes them to the DAC in standard I2S format (MSB first, one BCLK delay after LRCLK edge, 32-bit slots). It generates BCLK and LRCLK itself from the system clock, so the LRCLK it emits is the sample-rate edge that drives the rest of the chain.

## Interface
- CLK_DIV, 4: system clocks per BCLK half-period; must be ≥ 2.
- SLOT_BITS, 32: BCLK periods per channel slot; must be > 16.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_sample  in  16  signed sample, Q2.14.
- in_valid  in  1  writes in_sample to the channel holding register selected by in_chan.
- in_chan  in  1  0 = left, 1 = right.
- bclk  out  1  bit clock; reset 0.
- lrclk  out  1  0 = left slot, 1 = right slot; reset 1.
- sdata  out  1  serial data, changes only on BCLK falling edges; reset 0.
- underrun  out  1  one-clk pulse; slot loaded a holding register not written since its previous load; reset 0.
- overrun  out  1  one-clk pulse; holding register rewritten before being consumed; reset 0.

## Operation
- Holding registers hold_l, hold_r and flags fresh_l, fresh_r. in_valid writes the selected register and sets its fresh flag. If the flag was already set, pulse overrun and overwrite.
- Divider: div_cnt counts 0..CLK_DIV-1. At terminal count, bclk toggles.
- A fall event is a terminal count with bclk = 1. It updates bit_cnt, lrclk, and sdata on the same clk edge as bclk goes low.
- bit_cnt counts 0..SLOT_BITS-1 and wraps.
- On the fall event that makes bit_cnt = 0:
  - toggle lrclk;
  - load shift_reg from the holding register of the new channel (left if new lrclk = 0);
  - clear that channel's fresh flag;
  - if the flag was already clear, pulse underrun and retransmit the stale value.
- sdata by bit position:
  - bit_cnt = 0: 0 (padding);
  - bit_cnt = 1..16: sample bit 16−bit_cnt (MSB at bit 1);
  - bit_cnt = 17..SLOT_BITS-1: 0.
- Simultaneous in_valid and slot load for the same channel: the new in_sample is loaded directly into shift_reg. The fresh flag ends clear, with no underrun and no overrun.
- Reset state:
  - counters 0;
  - bit_cnt = SLOT_BITS-1, lrclk = 1, bclk = 0, sdata = 0;
  - holding registers 0, fresh flags 0.
  - The first fall event after reset therefore starts the left slot. Its underrun pulse is suppressed.
- Reset mid-frame abandons the frame immediately. Outputs return to reset values on the next clk.

## Timing
- BCLK period = 2·CLK_DIV clk. Frame = 2·SLOT_BITS BCLK periods.
- First bclk rise after reset: CLK_DIV clk cycles after reset deasserts. First fall: 2·CLK_DIV cycles after reset deasserts.
- The MSB is driven on the fall event one BCLK after the lrclk toggle. It is sampled by the DAC on the following rising edge.
- Latency from in_valid to MSB on sdata: at most one frame plus one BCLK period. The sample must be written before the slot-load fall event of its channel.
- underrun and overrun are single-cycle, registered, and asserted in the cycle after the causing event.
- lrclk and sdata never change on a BCLK rising edge.

## Structure
- Package i2s_pkg:
  - chan_t enum (CHAN_L = 0, CHAN_R = 1);
  - SAMPLE_W = 16;
  - default SLOT_BITS.
- Sub-module bclk_gen (divider): outputs bclk, plus single-cycle rise_evt and fall_evt strobes.
- Top level contains the holding registers, fresh flags, bit counter, shift register and flag logic.

## Test plan
All scenarios use CLK_DIV = 2, SLOT_BITS = 32.
- Reset release, no writes: bclk has period 4 clk, with first rise 2 clk and first fall 4 clk after reset release. lrclk falls at the first fall event. sdata stays 0. underrun pulses at every slot after the first.
- Write L = 16'hA5C3, R = 16'h8001 before the first slot: left slot bits 1..16 = 1010010111000011, right slot bits 1..16 = 1000000000000001, all other bits 0. No flags.
- Write L twice within one frame (16'h1234 then 16'h0F0F): one overrun pulse. The left slot transmits 16'h0F0F.
- Only R written each frame: left slot repeats its previous value, with one underrun pulse per left slot.
- in_valid with in_chan = 0 in the exact clk cycle of the left slot load, value 16'h7FFF: 16'h7FFF transmitted in that slot, no flags.
- Assert reset at bit 9 of the right slot: next clk gives bclk = 0, lrclk = 1, sdata = 0. The restart matches the first scenario.
